// File: rtl/mem_sram_responder.sv
// mem_sram_responder: in-order queued read responder driving an async wait-state SRAM
module mem_sram_responder #(
  parameter int QDEPTH = 4,
  parameter int WAIT_STATES = 2,
  parameter int ADDRW = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      addr,
  input  logic             readReq,
  output logic             busy,
  output logic             dataReady,
  output logic [15:0]      data,
  output logic             overflow,
  output logic [ADDRW-1:0] sram_addr,
  output logic             sram_ce_n,
  output logic             sram_oe_n,
  input  logic [15:0]      sram_dq
);
  localparam int PW = $clog2(QDEPTH);
  typedef enum logic {IDLE, ACCESS} state_t;
  state_t state, state_nx;
  logic [ADDRW-1:0] q [QDEPTH];
  logic [PW-1:0] wptr, rptr;
  logic [PW:0] cnt;
  logic [3:0] wcnt;
  logic pop, push, done;
  assign busy = cnt >= (PW+1)'(QDEPTH - 1);
  // pop on IDLE with work pending or on the last wait cycle; a pop frees a slot for a same-edge push
  always_comb begin
    done = state == ACCESS && wcnt == 4'd0;
    pop = cnt != '0 && (state == IDLE || done);
    push = readReq && (cnt != (PW+1)'(QDEPTH) || pop);
    state_nx = pop ? ACCESS : done ? IDLE : state;
  end
  // queue storage needs no reset; occupancy is governed by the pointers and count
  always_ff @(posedge clk) begin
    if (push) q[wptr] <= addr[ADDRW-1:0];
  end
  // queue pointers, occupancy and sticky overflow
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      cnt <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
      cnt <= cnt + (PW+1)'(push) - (PW+1)'(pop);
      overflow <= overflow | (readReq & ~push);
    end
  end
  // FSM state plus SRAM cycle and response registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      wcnt <= 4'd0;
      sram_addr <= '0;
      sram_ce_n <= 1'b1;
      sram_oe_n <= 1'b1;
      data <= 16'd0;
      dataReady <= 1'b0;
    end else begin
      state <= state_nx;
      dataReady <= done;
      if (done) data <= sram_dq;
      if (pop) begin
        sram_addr <= q[rptr];
        wcnt <= 4'(WAIT_STATES);
        sram_ce_n <= 1'b0;
        sram_oe_n <= 1'b0;
      end else if (done) begin
        sram_ce_n <= 1'b1;
        sram_oe_n <= 1'b1;
      end else if (wcnt != 4'd0) begin
        wcnt <= wcnt - 4'd1;
      end
    end
  end
endmodule

// File: tb/tb_mem_sram_responder.sv
// tb_mem_sram_responder: random stimulus vs. a service-schedule model on two wait-state configs
module tb_mem_sram_responder;
  logic clk, rst, readReq;
  logic [15:0] addr;
  logic [1:0] busy_v, dr_v, ovf_v, ce_v, oe_v;
  logic [15:0] data_v [2];
  logic [15:0] sa_v [2];
  int n_cmp = 0, n_err = 0;
  int sel = 0, t = -1, n = 0, resp = 0;
  int s_e [64];
  int r_e [64];
  logic [15:0] a_e [64];
  logic [15:0] m_data = '0;
  logic m_ovf = 1'b0;

  mem_sram_responder #(.QDEPTH(4), .WAIT_STATES(2), .ADDRW(16)) u_ws2 (
    .clk(clk), .rst(rst), .addr(addr), .readReq(readReq), .busy(busy_v[0]),
    .dataReady(dr_v[0]), .data(data_v[0]), .overflow(ovf_v[0]), .sram_addr(sa_v[0]),
    .sram_ce_n(ce_v[0]), .sram_oe_n(oe_v[0]), .sram_dq(~sa_v[0]));
  mem_sram_responder #(.QDEPTH(4), .WAIT_STATES(15), .ADDRW(16)) u_ws15 (
    .clk(clk), .rst(rst), .addr(addr), .readReq(readReq), .busy(busy_v[1]),
    .dataReady(dr_v[1]), .data(data_v[1]), .overflow(ovf_v[1]), .sram_addr(sa_v[1]),
    .sram_ce_n(ce_v[1]), .sram_oe_n(oe_v[1]), .sram_dq(~sa_v[1]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s t=%0d dut=%0d: got %0h expected %0h", tag, t, sel, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    readReq = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_busy", busy_v[i], 0);
      chk("rst_dataReady", dr_v[i], 0);
      chk("rst_overflow", ovf_v[i], 0);
      chk("rst_data", data_v[i], 0);
      chk("rst_sram_addr", sa_v[i], 0);
      chk("rst_ce_n", ce_v[i], 1);
      chk("rst_oe_n", oe_v[i], 1);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    t = -1;
    n = 0;
    resp = 0;
    m_data = '0;
    m_ovf = 1'b0;
  endtask

  // A request is served once the server is free and it has reached the queue head;
  // each service lasts ws+1 edges and responds on its last edge.
  task automatic step(input logic rq, input logic [15:0] a);
    int ws, cnt_b, cnt_a;
    bit pop, dr_e, act;
    logic [15:0] sa_e;
    ws = sel ? 15 : 2;
    readReq = rq;
    addr = a;
    @(posedge clk);
    t++;
    cnt_b = 0;
    pop = 0;
    for (int k = 0; k < n; k++) begin
      if (s_e[k] >= t) cnt_b++;
      if (s_e[k] == t) pop = 1;
    end
    if (rq) begin
      if (cnt_b < 4 || pop) begin
        s_e[n] = (n > 0 && r_e[n-1] > t + 1) ? r_e[n-1] : t + 1;
        r_e[n] = s_e[n] + ws + 1;
        a_e[n] = a;
        n++;
      end else m_ovf = 1'b1;
    end
    cnt_a = 0;
    dr_e = 0;
    act = 0;
    sa_e = '0;
    for (int k = 0; k < n; k++) begin
      if (s_e[k] > t) cnt_a++;
      if (r_e[k] == t) begin
        dr_e = 1;
        m_data = ~a_e[k];
      end
      if (s_e[k] <= t && t < r_e[k]) begin
        act = 1;
        sa_e = a_e[k];
      end
    end
    #1;
    readReq = 1'b0;
    if (dr_v[sel]) resp++;
    chk("dataReady", dr_v[sel], dr_e);
    chk("data", data_v[sel], m_data);
    chk("busy", busy_v[sel], cnt_a >= 3);
    chk("overflow", ovf_v[sel], m_ovf);
    chk("sram_ce_n", ce_v[sel], !act);
    chk("sram_oe_n", oe_v[sel], !act);
    if (act) chk("sram_addr", sa_v[sel], sa_e);
  endtask

  initial begin
    int issued, guard;
    readReq = 1'b0;
    addr = '0;
    rst = 1'b0;
    do_reset();
    sel = 0;
    step(1'b1, 16'h1234);
    repeat (6) step(1'b0, 16'h0);
    chk("single_data", data_v[0], 16'hEDCB);
    chk("single_resp", resp, 1);
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 16'h10 + 16'(i));
    repeat (12) step(1'b0, 16'h0);
    chk("b2b_resp", resp, 4);
    do_reset();
    sel = 1;
    issued = 0;
    guard = 0;
    while (issued < 5 && guard < 200) begin
      if (!busy_v[1]) begin
        step(1'b1, 16'($urandom));
        issued++;
      end else step(1'b0, 16'h0);
      guard++;
    end
    chk("busy_issued", issued, 5);
    repeat (90) step(1'b0, 16'h0);
    chk("busy_resp", resp, 5);
    chk("busy_no_ovf", ovf_v[1], 0);
    do_reset();
    repeat (7) step(1'b1, 16'($urandom));
    repeat (90) step(1'b0, 16'h0);
    chk("ovf_resp", resp, 5);
    chk("ovf_sticky", ovf_v[1], 1);
    do_reset();
    sel = 0;
    issued = 0;
    guard = 0;
    while (issued < 20 && guard < 2000) begin
      if (!busy_v[0] && $urandom_range(0, 2) != 0) begin
        step(1'b1, 16'($urandom));
        issued++;
      end else step(1'b0, 16'h0);
      guard++;
    end
    chk("wrap_issued", issued, 20);
    repeat (20) step(1'b0, 16'h0);
    chk("wrap_resp", resp, 20);
    chk("wrap_no_ovf", ovf_v[0], 0);
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 16'hA0 + 16'(i));
    step(1'b0, 16'h0);
    #2;
    do_reset();
    repeat (6) step(1'b0, 16'h0);
    chk("rst_no_stale", resp, 0);
    step(1'b1, 16'h5A5A);
    repeat (5) step(1'b0, 16'h0);
    chk("post_rst_resp", resp, 1);
    chk("post_rst_data", data_v[0], 16'hA5A5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mem_sram_responder.md
# mem_sram_responder

Read-only memory responder that terminates the upstream side of the memory scheduler's `memInternal` protocol. It sits between the scheduler output and an external asynchronous 16-bit SRAM. It queues incoming read requests, runs a fixed wait-state SRAM read cycle for each one, and returns `dataReady`/`data` strictly in request order, which the scheduler's owner ring buffer requires.

## Interface

Parameters:
- `QDEPTH`, default 4: request queue entries; power of two, ≥ 2.
- `WAIT_STATES`, default 2: extra SRAM cycles per read; range 0–15.
- `ADDRW`, default 16: SRAM address width, ≤ 16; uses `addr[ADDRW-1:0]`.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  sole clock
- `rst`  in  1  asynchronous, active-high reset
- `addr`  in  16  read address, valid with `readReq`
- `readReq`  in  1  single-cycle read request strobe
- `busy`  out  1  look-ahead back-pressure to scheduler
- `dataReady`  out  1  one-cycle pulse, `data` valid
- `data`  out  16  read data, registered
- `overflow`  out  1  sticky, request dropped on full queue
- `sram_addr`  out  ADDRW  SRAM address, registered
- `sram_ce_n`  out  1  SRAM chip enable, active-low, registered
- `sram_oe_n`  out  1  SRAM output enable, active-low, registered
- `sram_dq`  in  16  SRAM read data bus

## Operation

**Reset values**
- `busy`, `dataReady`, `overflow` = 0; `data` = 0; `sram_addr` = 0.
- `sram_ce_n` = `sram_oe_n` = 1.
- Queue empty; FSM in IDLE.

**Queue**
- Circular FIFO of `QDEPTH` addresses. Read/write pointers wrap modulo `QDEPTH`; a count register tracks occupancy.
- Push: `readReq` = 1 at a clock edge with a free slot. A slot freed by a pop at the same edge counts as free.
- Push and pop at the same edge: count unchanged.
- `readReq` with the queue full and no pop at that edge: request dropped, `overflow` set to 1 and held until reset, no response generated.
- `busy` = (count ≥ `QDEPTH`-1), decoded from the count register only. This is a look-ahead: the scheduler registers its request one cycle after sampling `busy`, so at most one more request can arrive after `busy` rises. `readReq` is still accepted while `busy` = 1 if a slot is free.

**FSM**
- IDLE:
  - Queue non-empty: pop head, `sram_addr` <= head, `sram_ce_n` <= 0, `sram_oe_n` <= 0, `wcnt` <= `WAIT_STATES`, go to ACCESS.
- ACCESS:
  - `wcnt` ≠ 0: decrement.
  - `wcnt` = 0: `data` <= `sram_dq`, `dataReady` <= 1 for exactly one cycle.
    - Queue non-empty: pop the next entry and reload `sram_addr`/`wcnt`, staying in ACCESS (back-to-back, strobes stay low).
    - Queue empty: `sram_ce_n`/`sram_oe_n` <= 1, go to IDLE.
- A request pushed at the same edge the queue goes empty is not visible to IDLE until the next edge. No same-edge bypass.
- `data` holds its last captured value between pulses.
- Responses leave in exact acceptance order; dropped requests produce no response.

**Reset mid-operation**
- Queue flushed, in-flight read abandoned, no `dataReady` is produced for it.
- SRAM strobes deassert immediately.

## Timing

- Each read occupies ACCESS for `WAIT_STATES`+1 cycles. `sram_addr` is stable the whole time, and `sram_dq` is sampled on the final edge.
- Latency with the queue empty and the FSM in IDLE: `readReq` sampled at edge N, `dataReady` high in the cycle after edge N+2+`WAIT_STATES`. With the default (2), that is edge N+4.
- Sustained throughput: one response per `WAIT_STATES`+1 cycles, with no idle cycle between back-to-back reads.
- `busy` follows the count with zero added latency: it changes in the cycle after the push or pop edge.
- All outputs are registered or decoded from registers only; there are no combinational paths from inputs to outputs.

## Test plan

- **Single read:** defaults; SRAM model returns `~addr`; `readReq` with `addr`=16'h1234 at edge 0 → `sram_ce_n`/`sram_oe_n` low from edge 1 to edge 4; `dataReady`=1 only in the cycle after edge 4 with `data`=16'hEDCB; strobes high after edge 4.
- **Back-to-back:** requests 0x10, 0x11, 0x12, 0x13 on consecutive edges 0–3 → `dataReady` pulses after edges 4, 7, 10, 13 with data `~0x10` … `~0x13` in order; `sram_ce_n` low continuously from edge 1 to edge 13.
- **Busy look-ahead:** `WAIT_STATES`=15; five requests on edges 0–4 → `busy` rises when count reaches 3, every request honoring `busy` is accepted, `overflow` stays 0.
- **Overflow:** `WAIT_STATES`=15; keep `readReq` high for 7 edges, ignoring `busy` → exactly `QDEPTH`+1 = 5 responses, `overflow`=1 from the first dropped request onward.
- **Pointer wrap:** 20 random addresses, each issued only when `busy`=0 → 20 responses, data order matches issue order, no `overflow`.
- **Reset mid-access:** assert `rst` two cycles into ACCESS with two entries queued → all outputs return to reset values within the reset cycle; after release, no stale `dataReady`; a new request completes with standard single-read latency.
